// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one {x1,y1,x2,y2,color} op in, one clipped
// {x,y,color} pixel per cycle out, walking all eight octants.
module line_raster_engine #(
   parameter int CW       = 10,
   parameter int COLW     = 12,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [4*CW+COLW-1:0]   in_op,
   input  logic                   in_rts,
   output logic                   in_rtr,
   output logic [2*CW+COLW-1:0]   out_pix,
   output logic                   out_rts,
   input  logic                   out_rtr,
   output logic                   out_last,
   output logic                   busy,
   output logic                   op_done
);

   localparam int EW = CW + 2;
   localparam logic [CW:0]   SW_L = SCREEN_W[CW:0];
   localparam logic [CW:0]   SH_L = SCREEN_H[CW:0];
   localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        x_q, x_d, y_q, y_d;
   logic [CW-1:0]        x2_q, x2_d, y2_q, y2_d;
   logic [COLW-1:0]      col_q, col_d;
   logic signed [CW:0]   dx_q, dx_d, dy_q, dy_d;
   logic                 sxn_q, sxn_d, syn_q, syn_d;
   logic signed [EW-1:0] err_q, err_d;
   logic                 op_done_q, op_done_d;

   logic                 in_bounds;
   logic                 at_end;
   logic                 step;
   logic                 fx, fy;
   logic [CW-1:0]        ax, ay;
   logic signed [EW:0]   e2, dx_w, dy_w;
   logic signed [EW-1:0] dx_e, dy_e;

   assign in_bounds = ({1'b0, x_q} < SW_L) && ({1'b0, y_q} < SH_L);
   assign at_end    = (x_q == x2_q) && (y_q == y2_q);
   assign step      = (state_q == DRAW) && (!in_bounds || out_rtr);

   // Decisions use the error term from before this step's update.
   assign e2   = {err_q, 1'b0};
   assign dx_w = {{2{dx_q[CW]}}, dx_q};
   assign dy_w = {{2{dy_q[CW]}}, dy_q};
   assign dx_e = {dx_q[CW], dx_q};
   assign dy_e = {dy_q[CW], dy_q};
   assign fx   = (e2 >= dy_w);
   assign fy   = (e2 <= dx_w);

   assign ax = (x2_q > x_q) ? (x2_q - x_q) : (x_q - x2_q);
   assign ay = (y2_q > y_q) ? (y2_q - y_q) : (y_q - y2_q);

   assign in_rtr   = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign out_rts  = (state_q == DRAW) && in_bounds;
   assign out_last = out_rts && at_end;
   assign op_done  = op_done_q;
   assign out_pix  = {x_q, y_q, col_q};

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      x2_d      = x2_q;
      y2_d      = y2_q;
      col_d     = col_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      sxn_d     = sxn_q;
      syn_d     = syn_q;
      err_d     = err_q;
      op_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_rts) begin
               x_d     = in_op[4*CW+COLW-1 -: CW];
               y_d     = in_op[3*CW+COLW-1 -: CW];
               x2_d    = in_op[2*CW+COLW-1 -: CW];
               y2_d    = in_op[CW+COLW-1 -: CW];
               col_d   = in_op[COLW-1:0];
               state_d = SETUP;
            end
         end
         SETUP: begin
            dx_d    = $signed({1'b0, ax});
            dy_d    = -$signed({1'b0, ay});
            sxn_d   = !(x_q < x2_q);
            syn_d   = !(y_q < y2_q);
            err_d   = $signed({1'b0, 1'b0, ax})
                    - $signed({1'b0, 1'b0, ay});
            state_d = DRAW;
         end
         DRAW: begin
            if (step) begin
               if (at_end) begin
                  state_d   = IDLE;
                  op_done_d = 1'b1;
               end else begin
                  err_d = err_q + (fx ? dy_e : '0)
                        + (fy ? dx_e : '0);
                  if (fx)
                     x_d = sxn_q ? (x_q - ONE) : (x_q + ONE);
                  if (fy)
                     y_d = syn_q ? (y_q - ONE) : (y_q + ONE);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         col_q     <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         sxn_q     <= 1'b0;
         syn_q     <= 1'b0;
         err_q     <= '0;
         op_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         col_q     <= col_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         sxn_q     <= sxn_d;
         syn_q     <= syn_d;
         err_q     <= err_d;
         op_done_q <= op_done_d;
      end
   end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: hand-derived Bresenham pixel
// sequences, clipping, degenerate op, backpressure and mid-line reset.
module tb_line_raster_engine;

   localparam int CW   = 10;
   localparam int COLW = 12;

   logic                 clk = 1'b0;
   logic                 rst_ = 1'b1;
   logic [4*CW+COLW-1:0] in_op = '0;
   logic                 in_rts = 1'b0;
   logic                 in_rtr;
   logic [2*CW+COLW-1:0] out_pix;
   logic                 out_rts;
   logic                 out_rtr = 1'b1;
   logic                 out_last;
   logic                 busy;
   logic                 op_done;

   int n_checks = 0;
   int n_fail   = 0;

   int got_x [0:31];
   int got_y [0:31];
   int got_c [0:31];
   bit got_l [0:31];
   int ex    [0:31];
   int ey    [0:31];
   int n_got;
   int done_cnt;
   int busy_cyc;

   line_raster_engine #(
      .CW(CW), .COLW(COLW), .SCREEN_W(640), .SCREEN_H(480)
   ) dut (
      .clk      (clk),
      .rst_     (rst_),
      .in_op    (in_op),
      .in_rts   (in_rts),
      .in_rtr   (in_rtr),
      .out_pix  (out_pix),
      .out_rts  (out_rts),
      .out_rtr  (out_rtr),
      .out_last (out_last),
      .busy     (busy),
      .op_done  (op_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, collect transferred pixels until op_done.
   // abort_at >= 0 applies reset once that many pixels have moved.
   task automatic run_op(input logic [CW-1:0] x1,
                         input logic [CW-1:0] y1,
                         input logic [CW-1:0] x2,
                         input logic [CW-1:0] y2,
                         input logic [COLW-1:0] col,
                         input bit rnd,
                         input int abort_at);
      bit stalled = 1'b0;
      bit seen_done = 1'b0;
      bit spurious = 1'b0;
      logic [2*CW+COLW-1:0] held = '0;
      n_got = 0;
      done_cnt = 0;
      busy_cyc = 0;
      @(negedge clk);
      check("in_rtr_idle", in_rtr, 1);
      in_op  = {x1, y1, x2, y2, col};
      in_rts = 1'b1;
      @(negedge clk);
      in_rts = 1'b0;
      check("in_rtr_busy", in_rtr, 0);
      for (int c = 0; c < 400; c++) begin
         if (stalled) check("hold_pix", out_pix, held);
         if (busy) busy_cyc++;
         if (op_done) begin
            done_cnt++;
            seen_done = 1'b1;
            check("in_rtr_after_done", in_rtr, 1);
            break;
         end
         if (abort_at >= 0 && n_got == abort_at) begin
            rst_ = 1'b1;
            out_rtr = 1'b1;
            @(negedge clk);
            check("abort_out_rts", out_rts, 0);
            check("abort_in_rtr", in_rtr, 1);
            check("abort_busy", busy, 0);
            check("abort_pix", out_pix, 0);
            rst_ = 1'b0;
            for (int k = 0; k < 6; k++) begin
               if (op_done || out_rts) spurious = 1'b1;
               @(negedge clk);
            end
            check("abort_quiet", spurious, 0);
            return;
         end
         out_rtr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = out_rts && !out_rtr;
         held = out_pix;
         if (out_rts && out_rtr && n_got < 32) begin
            got_x[n_got] = int'(out_pix[2*CW+COLW-1 -: CW]);
            got_y[n_got] = int'(out_pix[CW+COLW-1 -: CW]);
            got_c[n_got] = int'(out_pix[COLW-1:0]);
            got_l[n_got] = out_last;
            n_got++;
         end
         @(negedge clk);
      end
      out_rtr = 1'b1;
      check("op_done_seen", seen_done, 1);
   endtask

   task automatic verify(input string tag, input int ne,
                         input int col, input bit last_exp);
      check({tag, "_count"}, n_got, ne);
      check({tag, "_done"}, done_cnt, 1);
      for (int i = 0; i < ne && i < n_got; i++) begin
         check($sformatf("%s_x%0d", tag, i), got_x[i], ex[i]);
         check($sformatf("%s_y%0d", tag, i), got_y[i], ey[i]);
         check($sformatf("%s_c%0d", tag, i), got_c[i], col);
         check($sformatf("%s_l%0d", tag, i), got_l[i],
               last_exp && (i == ne - 1));
      end
   endtask

   task automatic load_case2;
      int xs [0:10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
      for (int i = 0; i < 11; i++) begin
         ex[i] = xs[i];
         ey[i] = i;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_rtr", in_rtr, 1);
      check("rst_out_rts", out_rts, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_op_done", op_done, 0);
      check("rst_out_pix", out_pix, 0);
      rst_ = 1'b0;

      // Horizontal run
      for (int i = 0; i < 6; i++) begin
         ex[i] = i;
         ey[i] = 0;
      end
      run_op(0, 0, 5, 0, 12'habc, 0, -1);
      verify("c1", 6, 'habc, 1);
      check("c1_busy_cyc", busy_cyc, 7);

      // Steep line, y-major
      load_case2();
      run_op(0, 0, 5, 10, 12'h123, 0, -1);
      verify("c2", 11, 'h123, 1);

      // Same line walked backwards
      begin
         int xs [0:10] = '{5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
         for (int i = 0; i < 11; i++) begin
            ex[i] = xs[i];
            ey[i] = 10 - i;
         end
      end
      run_op(5, 10, 0, 0, 12'h456, 0, -1);
      verify("c3", 11, 'h456, 1);

      // Degenerate single point
      ex[0] = 3;
      ey[0] = 3;
      run_op(3, 3, 3, 3, 12'h7e7, 0, -1);
      verify("c4", 1, 'h7e7, 1);
      check("c4_busy_cyc", busy_cyc, 2);

      // Runs off the right edge: endpoint clipped
      for (int i = 0; i < 10; i++) begin
         ex[i] = 630 + i;
         ey[i] = 0;
      end
      run_op(630, 0, 645, 0, 12'h0f0, 0, -1);
      verify("c5", 10, 'h0f0, 0);
      check("c5_busy_cyc", busy_cyc, 17);

      // Random backpressure, then mid-line reset, then recovery
      load_case2();
      run_op(0, 0, 5, 10, 12'h9a5, 1, -1);
      verify("c6", 11, 'h9a5, 1);
      run_op(0, 0, 5, 10, 12'h9a5, 1, 4);
      check("c6_abort_count", n_got, 4);
      check("c6_abort_done", done_cnt, 0);
      run_op(0, 0, 5, 10, 12'h3c3, 1, -1);
      verify("c6r", 11, 'h3c3, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
